// File: rtl/zrb_uart_rx_os_if.sv
// zrb_uart_rx_os_if
// Output word channel of the oversampling UART receiver.
//
// Handshake: the receiver (master) raises valid together with data_out and
// the per-word flags, and holds all of them stable until the consumer
// (slave) takes the word. A word is taken on any rising clk edge where
// valid & ready are both 1. ready may be high at any time and is ignored
// while valid is 0. overrun is a sticky status bit that travels with the
// channel and clears when a word is taken.
//
// Signals:
//   data_out   [NUM_BITS]  received word, LSB = first data bit on the line
//   valid                  data_out and flags are valid
//   ready                  consumer accepts the word when valid & ready
//   parity_err             parity mismatch for the held word
//   frame_err              a stop bit was sampled 0 for the held word
//   break_det              data, parity and first stop bit were all 0
//   overrun                a completed frame was dropped while valid was high
interface zrb_uart_rx_os_if #(
  parameter int NUM_BITS = 8
);
  logic [NUM_BITS-1:0] data_out;
  logic                valid;
  logic                ready;
  logic                parity_err;
  logic                frame_err;
  logic                break_det;
  logic                overrun;

  modport master (
    output data_out, valid, parity_err, frame_err, break_det, overrun,
    input  ready
  );

  modport slave (
    input  data_out, valid, parity_err, frame_err, break_det, overrun,
    output ready
  );
endinterface

// File: rtl/zrb_uart_rx_os.sv
// zrb_uart_rx_os
// Oversampling UART receiver. The serial line is synchronised, sampled on
// every clk_en tick (OVERSAMPLE ticks per bit) and each bit is decided by a
// 3-sample majority vote around the bit centre. Completed words are offered
// on a valid/ready holding register together with parity, framing and break
// flags; a frame that completes while the previous word is still unread is
// dropped and flagged as overrun.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   clk_en     oversample tick, one clk wide, OVERSAMPLE x baud
//   rx         serial line, idle high, asynchronous to clk
//   bus        word output channel (see zrb_uart_rx_os_if)
//   busy       receiver FSM is not in IDLE
//   state_dbg  current FSM state encoding
module zrb_uart_rx_os #(
  parameter int    NUM_BITS   = 8,
  parameter string PARITY     = "NO",
  parameter int    STOP_BITS  = 1,
  parameter int    OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             rx,
  zrb_uart_rx_os_if.master bus,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam int M  = OVERSAMPLE / 2;

  localparam logic [TW-1:0] T_S0   = TW'(M - 1);
  localparam logic [TW-1:0] T_S1   = TW'(M);
  localparam logic [TW-1:0] T_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(NUM_BITS - 1);
  localparam logic          S_LAST = 1'(STOP_BITS - 1);

  localparam bit PAR_EN  = (PARITY != "NO");
  localparam bit PAR_ODD = (PARITY == "ODD");

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // line synchroniser
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // frame sequencing
  state_t              state_q, state_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic                stop_q, stop_d;
  logic [1:0]          samp_q, samp_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic                par_bit_q, par_bit_d;
  logic                par_err_int_q, par_err_int_d;
  logic                frame_err_int_q, frame_err_int_d;
  logic                brk_int_q, brk_int_d;

  // output holding register
  logic [NUM_BITS-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                pe_q, pe_d;
  logic                fe_q, fe_d;
  logic                bd_q, bd_d;
  logic                ovr_q, ovr_d;
  logic                busy_q, busy_d;

  logic maj;
  logic dec;
  logic end_bit;
  logic done;
  logic accept;

  // Two stored samples (ticks M-1, M) plus the live sample at tick M+1.
  assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) |
                   (samp_q[1] & rx_s_q);
  assign dec     = clk_en && (tick_q == T_DEC);
  assign end_bit = clk_en && (tick_q == T_LAST);
  assign accept  = valid_q & bus.ready;

  always_comb begin
    rx_meta_d       = rx;
    rx_s_d          = rx_meta_q;
    state_d         = state_q;
    tick_d          = tick_q;
    bit_d           = bit_q;
    stop_d          = stop_q;
    samp_d          = samp_q;
    shift_d         = shift_q;
    par_bit_d       = par_bit_q;
    par_err_int_d   = par_err_int_q;
    frame_err_int_d = frame_err_int_q;
    brk_int_d       = brk_int_q;
    done            = 1'b0;

    if (clk_en) begin
      tick_d = (tick_q == T_LAST) ? '0 : tick_q + TW'(1);
      if (tick_q == T_S0) samp_d[0] = rx_s_q;
      if (tick_q == T_S1) samp_d[1] = rx_s_q;

      case (state_q)
        S_IDLE: begin
          tick_d = '0;
          if (!rx_s_q) begin
            state_d         = S_START;
            par_bit_d       = 1'b0;
            par_err_int_d   = 1'b0;
            frame_err_int_d = 1'b0;
            brk_int_d       = 1'b0;
          end
        end
        S_START: begin
          if (dec && maj) begin
            // line went back high before the bit centre: glitch, not a start
            state_d = S_IDLE;
            tick_d  = '0;
          end else if (end_bit) begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
        S_DATA: begin
          if (dec) shift_d = {maj, shift_q[NUM_BITS-1:1]};
          if (end_bit) begin
            if (bit_q == B_LAST) begin
              state_d = PAR_EN ? S_PARITY : S_STOP;
              bit_d   = '0;
              stop_d  = 1'b0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        S_PARITY: begin
          if (dec) begin
            par_bit_d     = maj;
            par_err_int_d = ((^shift_q) ^ maj) != PAR_ODD;
          end
          if (end_bit) begin
            state_d = S_STOP;
            stop_d  = 1'b0;
          end
        end
        S_STOP: begin
          if (dec) begin
            if (!maj) frame_err_int_d = 1'b1;
            if (stop_q == 1'b0)
              brk_int_d = (shift_q == '0) && !par_bit_q && !maj;
            if (stop_q == S_LAST) begin
              // leave at the last stop decision so the next start edge is
              // caught even when frames are sent back to back
              done    = 1'b1;
              state_d = S_IDLE;
              tick_d  = '0;
            end
          end else if (end_bit) begin
            stop_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    data_d = data_q;
    valid_d = valid_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    bd_d    = bd_q;
    ovr_d   = ovr_q;
    busy_d  = (state_d != S_IDLE);

    if (accept) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
    // a commit in the same cycle as an accept refills the register
    if (done) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        pe_d    = par_err_int_q;
        fe_d    = frame_err_int_d | brk_int_d;
        bd_d    = brk_int_d;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q       <= 1'b1;
      rx_s_q          <= 1'b1;
      state_q         <= S_IDLE;
      tick_q          <= '0;
      bit_q           <= '0;
      stop_q          <= 1'b0;
      samp_q          <= 2'b11;
      shift_q         <= '0;
      par_bit_q       <= 1'b0;
      par_err_int_q   <= 1'b0;
      frame_err_int_q <= 1'b0;
      brk_int_q       <= 1'b0;
      data_q          <= '0;
      valid_q         <= 1'b0;
      pe_q            <= 1'b0;
      fe_q            <= 1'b0;
      bd_q            <= 1'b0;
      ovr_q           <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      rx_meta_q       <= rx_meta_d;
      rx_s_q          <= rx_s_d;
      state_q         <= state_d;
      tick_q          <= tick_d;
      bit_q           <= bit_d;
      stop_q          <= stop_d;
      samp_q          <= samp_d;
      shift_q         <= shift_d;
      par_bit_q       <= par_bit_d;
      par_err_int_q   <= par_err_int_d;
      frame_err_int_q <= frame_err_int_d;
      brk_int_q       <= brk_int_d;
      data_q          <= data_d;
      valid_q         <= valid_d;
      pe_q            <= pe_d;
      fe_q            <= fe_d;
      bd_q            <= bd_d;
      ovr_q           <= ovr_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = pe_q;
  assign bus.frame_err  = fe_q;
  assign bus.break_det  = bd_q;
  assign bus.overrun    = ovr_q;
  assign busy           = busy_q;
  assign state_dbg      = state_q;

endmodule

// File: doc/zrb_uart_rx_os.md
Name: zrb_uart_rx_os

Overview:
- Parametrised oversampling UART receiver; next generation of the codebase UART RX.
- Configurable data width, parity, stop bits and oversample ratio.
- 3-sample majority vote per bit, false-start rejection, and parity, framing, break and overrun detection.
- Presents each received word through a valid/ready holding register to downstream logic (FIFO, command parser); driven by a baud-generator enable at OVERSAMPLE x baud.

Parameters:
NUM_BITS, 8, data bits per frame, legal 5..9
PARITY, "NO", "NO" / "EVEN" / "ODD"
STOP_BITS, 1, stop bits checked, legal 1 or 2
OVERSAMPLE, 16, clk_en ticks per bit, legal 8 or 16

Ports:
clk  in  1  system clock, all logic rising-edge
reset  in  1  asynchronous, active-low reset (asserted at 0)
clk_en  in  1  oversample tick, one clk wide, rate OVERSAMPLE x baud
rx  in  1  serial line, idle high, asynchronous to clk
data_out  out  NUM_BITS  received word, LSB = first data bit
valid  out  1  data_out and the flags below are valid
ready  in  1  consumer accepts word when valid & ready
parity_err  out  1  parity mismatch for the held word (always 0 when PARITY="NO")
frame_err  out  1  any stop bit sampled 0 for the held word
break_det  out  1  data, parity and first stop bit all 0 for the held word
overrun  out  1  sticky: a completed frame was dropped because valid was high
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset=0, async): FSM=IDLE; synchroniser flops=1; data_out=0; valid=0; parity_err=0; frame_err=0; break_det=0; overrun=0; busy=0; tick and bit counters=0. Reset asserted mid-frame abandons the frame with no output.
- rx passes through 2 flops (rx_s) before any use.
- tick_cnt runs 0..OVERSAMPLE-1 and advances only on clk_en. M = OVERSAMPLE/2.
- Bit value = majority of rx_s taken on ticks M-1, M and M+1. Decision is made on the clk_en cycle with tick_cnt=M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a clk_en cycle with rx_s=0, go to START with tick_cnt=0.
  - START: if the majority is 1 at decision, this is a false start; go to IDLE with no output. Else continue; at tick_cnt=OVERSAMPLE-1, go to DATA with bit_cnt=0.
  - DATA: shift the decided bit in LSB-first. At end of bit (tick OVERSAMPLE-1), bit_cnt++. After NUM_BITS bits, go to PARITY if PARITY != "NO", else STOP.
  - PARITY: at decision, compute error = (XOR of data bits ^ parity bit) != (PARITY=="ODD"). At end of bit, go to STOP.
  - STOP: decide each stop bit; any stop bit = 0 sets frame_err_int. The frame completes at the decision of the last stop bit; the FSM returns to IDLE on the same clk_en cycle without waiting for end of bit, so the receiver resyncs on back-to-back frames.
- Commit on the clk edge after the completing clk_en cycle:
  - If valid=0 or (valid & ready) in that cycle: load data_out and all error flags, and set valid=1.
  - Otherwise drop the new frame, keep the old word, and set overrun=1.
- valid clears on valid & ready unless a commit occurs in the same cycle; commit wins and valid stays 1.
- overrun is sticky; it clears only when the consumer accepts the word (valid & ready).
- break_det=1 additionally forces frame_err=1.
- Arithmetic: all counters wrap-free. bit_cnt width = clog2(NUM_BITS+1). Parity is a pure XOR reduction; no overflow cases.
- clk_en low stalls the FSM indefinitely with state held. ready is ignored while valid=0.

Test Plan:
- Default params, clk_en every 4th clk, frame 0xA5 sent at 1 bit = 64 clk, ready=1 -> valid one-clk pulse, data_out=0xA5, all flags 0.
- PARITY="EVEN"; send 0x03 with parity bit 1 -> data_out=0x03, parity_err=1. Resend with parity bit 0 -> parity_err=0. With PARITY="ODD", 0x03 + parity bit 1 -> parity_err=0.
- 3-tick rx glitch low in idle, then high -> no valid, busy returns 0 after the start-bit decision. A single-tick low spike on sample M of data bit 2 of 0xFF -> data_out=0xFF (majority vote).
- STOP_BITS=2; 0x55 with second stop bit 0 -> frame_err=1. Line held 0 for 12 bit-times -> data_out=0x00, break_det=1, frame_err=1.
- ready=0; send 0x11 then 0x22 back-to-back -> data_out stays 0x11, overrun=1. Raise ready for 1 clk -> valid and overrun clear.
- Assert reset mid DATA bit 4 of 0x3C, release, send 0xC3 -> single valid with 0xC3, no stale word, flags 0.
